// File: rtl/exe_mem_req_if.sv
// rtl/exe_mem_req_if.sv - SRAM-like request/response bus between exe_mem_req and memory
interface exe_mem_req_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                req;
   logic                wr;
   logic [1:0]          size;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W/8-1:0] wstrb;
   logic [DATA_W-1:0]   wdata;
   logic                addr_ok;
   logic                data_ok;
   logic [DATA_W-1:0]   rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/exe_mem_req.sv
// rtl/exe_mem_req.sv - execute-stage load/store request unit with held result register
// EXE_MEM_ALE_EN: trap misaligned ops as exc_ale instead of forcing them aligned
module exe_mem_req #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_store,
   input  logic [1:0]        in_size,
   input  logic              in_sign,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              flush,
   exe_mem_req_if.master     mem,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DEST_W-1:0] out_dest,
   output logic              exc_ale,
   output logic [ADDR_W-1:0] bad_addr
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NB-1:0]       wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                sign_q, sign_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic                cancel_q, cancel_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [DEST_W-1:0]   out_dest_q, out_dest_d;
`ifdef EXE_MEM_ALE_EN
   logic                exc_ale_q, exc_ale_d;
   logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;
   logic                misaligned;
`endif

   logic [OFF_W-1:0]    in_off, size_mask, eff_off;
   logic [NB-1:0]       in_strb;
   logic [DATA_W-1:0]   in_rep;
   logic [DATA_W-1:0]   shifted, ld_data;
   logic                sbit;
   logic                accept;

   // Lane offset is rounded down to the access size so an unaligned op still hits legal lanes.
   always_comb begin
      in_off    = in_addr[OFF_W-1:0];
      size_mask = OFF_W'((32'd1 << in_size) - 32'd1);
      eff_off   = in_off & ~size_mask;
`ifdef EXE_MEM_ALE_EN
      misaligned = (in_off & size_mask) != '0;
`endif
      in_strb = '0;
      in_rep  = '0;
      for (int b = 0; b < NB; b++) begin
         if (b >= int'(eff_off) && b < int'(eff_off) + (1 << in_size))
            in_strb[b] = 1'b1;
         in_rep[8*b +: 8] = in_wdata[8*(b & int'(size_mask)) +: 8];
      end
   end

   // Loaded bytes come down to lane 0; bytes above the access size take the extension bit.
   always_comb begin
      shifted = mem.rdata >> {off_q, 3'b000};
      ld_data = '0;
      sbit    = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (b < (1 << size_q)) begin
            ld_data[8*b +: 8] = shifted[8*b +: 8];
            sbit              = shifted[8*b + 7];
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (b >= (1 << size_q))
            ld_data[8*b +: 8] = {8{sign_q & sbit}};
      end
   end

   always_comb begin
      in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
      accept      = in_valid && in_ready;
      state_d     = state_q;
      req_d       = req_q;
      wr_d        = wr_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      sign_d      = sign_q;
      off_d       = off_q;
      dest_d      = dest_q;
      cancel_d    = cancel_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
`ifdef EXE_MEM_ALE_EN
      exc_ale_d   = exc_ale_q;
      bad_addr_d  = bad_addr_q;
`endif
      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;
      if (flush)
         out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               wr_d     = in_store;
               size_d   = in_size;
               addr_d   = {in_addr[ADDR_W-1:OFF_W], eff_off};
               wstrb_d  = in_store ? in_strb : '0;
               wdata_d  = in_rep;
               sign_d   = in_sign;
               off_d    = eff_off;
               dest_d   = in_dest;
               cancel_d = 1'b0;
`ifdef EXE_MEM_ALE_EN
               if (misaligned) begin
                  out_valid_d = 1'b1;
                  out_data_d  = '0;
                  out_dest_d  = in_store ? '0 : in_dest;
                  exc_ale_d   = 1'b1;
                  bad_addr_d  = in_addr;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
`else
               state_d = S_REQ;
               req_d   = 1'b1;
`endif
            end
         end
         S_REQ: begin
            if (mem.addr_ok) begin
               state_d  = S_WAIT;
               req_d    = 1'b0;
               cancel_d = flush;
            end else if (flush) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (flush)
               cancel_d = 1'b1;
            if (mem.data_ok) begin
               state_d  = S_IDLE;
               cancel_d = 1'b0;
               if (!cancel_q && !flush) begin
                  out_valid_d = 1'b1;
                  out_data_d  = wr_q ? '0 : ld_data;
                  out_dest_d  = wr_q ? '0 : dest_q;
`ifdef EXE_MEM_ALE_EN
                  exc_ale_d   = 1'b0;
                  bad_addr_d  = '0;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         wr_q        <= 1'b0;
         size_q      <= '0;
         addr_q      <= '0;
         wstrb_q     <= '0;
         wdata_q     <= '0;
         sign_q      <= 1'b0;
         off_q       <= '0;
         dest_q      <= '0;
         cancel_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
`ifdef EXE_MEM_ALE_EN
         exc_ale_q   <= 1'b0;
         bad_addr_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         sign_q      <= sign_d;
         off_q       <= off_d;
         dest_q      <= dest_d;
         cancel_q    <= cancel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
`ifdef EXE_MEM_ALE_EN
         exc_ale_q   <= exc_ale_d;
         bad_addr_q  <= bad_addr_d;
`endif
      end
   end

   assign mem.req   = req_q;
   assign mem.wr    = wr_q;
   assign mem.size  = size_q;
   assign mem.addr  = addr_q;
   assign mem.wstrb = wstrb_q;
   assign mem.wdata = wdata_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_dest  = out_dest_q;
`ifdef EXE_MEM_ALE_EN
   assign exc_ale   = exc_ale_q;
   assign bad_addr  = bad_addr_q;
`else
   assign exc_ale   = 1'b0;
   assign bad_addr  = '0;
`endif
endmodule

// File: tb/tb_exe_mem_req.sv
// tb/tb_exe_mem_req.sv - bench for exe_mem_req: 32- and 64-bit instances in lockstep
module tb_exe_mem_req;
   typedef struct {
      bit          w64;
      logic        st;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] ad;
      logic [63:0] wd;
      logic [4:0]  dst;
      logic [63:0] rd;
      int          stall;
      int          hold;
      logic [63:0] e_addr;
      logic [63:0] e_strb;
      logic [63:0] e_wdata;
      logic [63:0] e_out;
      logic [63:0] e_dest;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_store = 1'b0, in_sign = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [1:0]  in_size = '0;
   logic [31:0] in_addr = '0;
   logic [63:0] in_wdata = '0, rdata = '0;
   logic [4:0]  in_dest = '0;
   logic        addr_ok = 1'b0, data_ok = 1'b0;
   bit          cur_w64 = 1'b0;

   logic        rdy32, rdy64, ov32, ov64, exc32, exc64;
   logic [31:0] od32, bad32, bad64;
   logic [63:0] od64;
   logic [4:0]  dst32, dst64;

   logic [63:0] s_req, s_addr, s_wr, s_wstrb, s_wdata, s_in_ready, s_out_valid, s_out_data, s_out_dest, s_exc;

   int   checks = 0;
   int   errs = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   exe_mem_req_if #(.DATA_W(32), .ADDR_W(32)) m32 ();
   exe_mem_req_if #(.DATA_W(64), .ADDR_W(32)) m64 ();
   assign m32.addr_ok = addr_ok;
   assign m32.data_ok = data_ok;
   assign m32.rdata   = rdata[31:0];
   assign m64.addr_ok = addr_ok;
   assign m64.data_ok = data_ok;
   assign m64.rdata   = rdata;

   exe_mem_req #(.DATA_W(32), .ADDR_W(32), .DEST_W(5)) u32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_store(in_store),
      .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
      .in_dest(in_dest), .flush(flush), .mem(m32), .out_valid(ov32), .out_ready(out_ready),
      .out_data(od32), .out_dest(dst32), .exc_ale(exc32), .bad_addr(bad32)
   );

   exe_mem_req #(.DATA_W(64), .ADDR_W(32), .DEST_W(5)) u64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_store(in_store),
      .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_dest(in_dest), .flush(flush), .mem(m64), .out_valid(ov64), .out_ready(out_ready),
      .out_data(od64), .out_dest(dst64), .exc_ale(exc64), .bad_addr(bad64)
   );

   always_comb begin
      if (cur_w64) begin
         s_req = 64'(m64.req);   s_addr = 64'(m64.addr);   s_wr = 64'(m64.wr);
         s_wstrb = 64'(m64.wstrb); s_wdata = m64.wdata;    s_in_ready = 64'(rdy64);
         s_out_valid = 64'(ov64); s_out_data = od64;       s_out_dest = 64'(dst64);
         s_exc = 64'(exc64);
      end else begin
         s_req = 64'(m32.req);   s_addr = 64'(m32.addr);   s_wr = 64'(m32.wr);
         s_wstrb = 64'(m32.wstrb); s_wdata = 64'(m32.wdata); s_in_ready = 64'(rdy32);
         s_out_valid = 64'(ov32); s_out_data = 64'(od32);  s_out_dest = 64'(dst32);
         s_exc = 64'(exc32);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cur_w64  = v.w64;
      in_valid = 1'b1;
      in_store = v.st;
      in_size  = v.sz;
      in_sign  = v.sg;
      in_addr  = v.ad;
      in_wdata = v.wd;
      in_dest  = v.dst;
   endtask

   // Entered and left at posedge+1; the DUT is expected at its minimum latency.
   task automatic run_vec(input vec_t v);
      vec_t e;
      out_ready = 1'b1;
      drive(v);
      @(negedge clk);
      chk("in_ready", s_in_ready, 64'd1);
      exp_q.push_back(v);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("req_rise", s_req, 64'd1);
      chk("addr", s_addr, v.e_addr);
      chk("wr", s_wr, 64'(v.st));
      chk("wstrb", s_wstrb, v.e_strb);
      if (v.st) chk("wdata", s_wdata, v.e_wdata);
      for (int i = 0; i < v.stall; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("req_hold", s_req, 64'd1);
         chk("addr_hold", s_addr, v.e_addr);
      end
      addr_ok = 1'b1;
      @(posedge clk); #1;
      addr_ok   = 1'b0;
      data_ok   = 1'b1;
      rdata     = v.rd;
      out_ready = (v.hold == 0);
      @(negedge clk);
      chk("req_drop", s_req, 64'd0);
      @(posedge clk); #1 data_ok = 1'b0;
      @(negedge clk);
      chk("out_valid", s_out_valid, 64'd1);
      e = exp_q.pop_front();
      chk("out_data", s_out_data, e.e_out);
      chk("out_dest", s_out_dest, e.e_dest);
      chk("exc_ale", s_exc, 64'd0);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("held_valid", s_out_valid, 64'd1);
         chk("held_data", s_out_data, e.e_out);
         chk("held_in_ready", s_in_ready, 64'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{1'b0,1'b1,2'd0,1'b0,32'h1003,64'hA5,5'd7,64'h0,0,0,64'h1003,64'h08,64'hA5A5A5A5,64'h0,64'h0});
      vecs.push_back('{1'b0,1'b0,2'd1,1'b1,32'h2002,64'h0,5'd3,64'h80011234,0,0,64'h2002,64'h0,64'h0,64'hFFFF8001,64'd3});
      vecs.push_back('{1'b0,1'b0,2'd1,1'b0,32'h2002,64'h0,5'd4,64'h80011234,0,0,64'h2002,64'h0,64'h0,64'h8001,64'd4});
      vecs.push_back('{1'b1,1'b1,2'd3,1'b0,32'h10,64'h1122334455667788,5'd1,64'h0,0,0,64'h10,64'hFF,64'h1122334455667788,64'h0,64'h0});
      vecs.push_back('{1'b1,1'b0,2'd2,1'b1,32'h14,64'h0,5'd9,64'h7FFFFFFFDEADBEEF,0,0,64'h14,64'h0,64'h0,64'h7FFFFFFF,64'd9});
      vecs.push_back('{1'b0,1'b1,2'd2,1'b0,32'h3000,64'hCAFEBABE,5'd2,64'h0,5,0,64'h3000,64'h0F,64'hCAFEBABE,64'h0,64'h0});
      vecs.push_back('{1'b0,1'b0,2'd0,1'b1,32'h4001,64'h0,5'd12,64'h1234F678,0,0,64'h4001,64'h0,64'h0,64'hFFFFFFF6,64'd12});
      vecs.push_back('{1'b0,1'b1,2'd1,1'b0,32'h5002,64'hBEEF,5'd0,64'h0,0,0,64'h5002,64'h0C,64'hBEEFBEEF,64'h0,64'h0});
      vecs.push_back('{1'b1,1'b1,2'd0,1'b0,32'h27,64'h5A,5'd0,64'h0,0,0,64'h27,64'h80,64'h5A5A5A5A5A5A5A5A,64'h0,64'h0});
      vecs.push_back('{1'b1,1'b0,2'd1,1'b0,32'h26,64'h0,5'd20,64'hABCD000000000000,0,0,64'h26,64'h0,64'h0,64'hABCD,64'd20});
      vecs.push_back('{1'b1,1'b0,2'd0,1'b1,32'h23,64'h0,5'd31,64'h80000000,0,0,64'h23,64'h0,64'h0,64'hFFFFFFFFFFFFFF80,64'd31});

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_req32", 64'(m32.req), 64'd0);
      chk("rst_req64", 64'(m64.req), 64'd0);
      chk("rst_wr32", 64'(m32.wr), 64'd0);
      chk("rst_wstrb64", 64'(m64.wstrb), 64'd0);
      chk("rst_wdata64", m64.wdata, 64'd0);
      chk("rst_addr32", 64'(m32.addr), 64'd0);
      chk("rst_ov32", 64'(ov32), 64'd0);
      chk("rst_ov64", 64'(ov64), 64'd0);
      chk("rst_od64", od64, 64'd0);
      chk("rst_exc32", 64'(exc32), 64'd0);
      chk("rst_bad64", 64'(bad64), 64'd0);
      chk("rst_in_ready32", 64'(rdy32), 64'd1);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // flush while the request is still waiting for addr_ok
      cur_w64 = 1'b0; in_valid = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h9000;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("flreq_req", s_req, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flreq_drop", s_req, 64'd0);
      chk("flreq_idle", s_in_ready, 64'd1);
      @(posedge clk); #1;

      // flush after addr_ok: the response must be swallowed
      in_valid = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h8000;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("flwait_req", s_req, 64'd1);
      addr_ok = 1'b1;
      @(posedge clk); #1 addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk("flwait_busy", s_in_ready, 64'd0);
      @(posedge clk); #1 flush = 1'b0; data_ok = 1'b1; rdata = 64'h55;
      @(negedge clk);
      chk("flwait_still_busy", s_in_ready, 64'd0);
      @(posedge clk); #1 data_ok = 1'b0;
      @(negedge clk);
      chk("flwait_no_out", s_out_valid, 64'd0);
      chk("flwait_idle", s_in_ready, 64'd1);
      @(posedge clk); #1;

      // held result, then a new op accepted in the same cycle it drains
      run_vec('{1'b0,1'b0,2'd2,1'b0,32'h7000,64'h0,5'd2,64'h0BADF00D,0,3,64'h7000,64'h0,64'h0,64'h0BADF00D,64'd2});
      run_vec('{1'b0,1'b0,2'd2,1'b1,32'h7004,64'h0,5'd6,64'h13579BDF,0,0,64'h7004,64'h0,64'h0,64'h13579BDF,64'd6});

      // reset while a request is outstanding; a late data_ok must not produce a result
      in_valid = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'hA000;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("rstop_req", s_req, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; data_ok = 1'b1;
      @(negedge clk);
      chk("rstop_req_drop", s_req, 64'd0);
      @(posedge clk); #1 data_ok = 1'b0;
      @(negedge clk);
      chk("rstop_no_out", s_out_valid, 64'd0);
      chk("rstop_idle", s_in_ready, 64'd1);
      @(posedge clk); #1;

`ifdef EXE_MEM_ALE_EN
      cur_w64 = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h1002; in_dest = 5'd8;
      @(negedge clk);
      chk("ale_in_ready", s_in_ready, 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("ale_no_req", s_req, 64'd0);
      chk("ale_valid", s_out_valid, 64'd1);
      chk("ale_exc", s_exc, 64'd1);
      chk("ale_bad_addr", 64'(bad32), 64'h1002);
      chk("ale_data", s_out_data, 64'd0);
      @(posedge clk); #1;
`else
      run_vec('{1'b0,1'b0,2'd2,1'b0,32'h1002,64'h0,5'd5,64'h89ABCDEF,0,0,64'h1000,64'h0,64'h0,64'h89ABCDEF,64'd5});
      chk("noale_bad_addr", 64'(bad32), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/exe_mem_req.md
Name: exe_mem_req

Overview:
- Parametrised execute-stage load/store request unit with a registered SRAM-like request/response handshake (req/addr_ok/data_ok).
- Decouples the memory port from the execute ALU.
- Generalises byte-lane write-strobe/data generation to DATA_W of 32 or 64.
- Adds load-data alignment and extension, flush cancellation, and a held result register toward the memory stage.

Parameters:
DATA_W, 32, data bus width; 32 or 64 only.
ADDR_W, 32, address width.
DEST_W, 5, destination register index width.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  memory op offered by execute
in_ready  output  1  op accepted this cycle when in_valid&in_ready
in_store  input  1  1=store, 0=load
in_size  input  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
in_sign  input  1  sign-extend load result
in_addr  input  ADDR_W  effective address
in_wdata  input  DATA_W  store source, LSB-aligned
in_dest  input  DEST_W  load destination
flush  input  1  cancel current op
req  output  1  memory request valid
wr  output  1  request is write
size  output  2  copy of in_size
addr  output  ADDR_W  request address
wstrb  output  DATA_W/8  byte write enables
wdata  output  DATA_W  lane-replicated store data
addr_ok  input  1  request accepted
data_ok  input  1  response / write complete
rdata  input  DATA_W  raw read data
out_valid  output  1  result valid to memory stage
out_ready  input  1  memory stage accepts
out_data  output  DATA_W  aligned, extended load data; 0 for stores
out_dest  output  DEST_W  destination; 0 for stores
exc_ale  output  1  misaligned exception, valid with out_valid
bad_addr  output  ADDR_W  faulting address

Behaviour:
- Reset values: req, wr, wstrb, wdata, addr, size, out_valid, out_data, out_dest, exc_ale, bad_addr = 0. FSM = IDLE.
- Shared definitions:
  - off = addr[log2(DATA_W/8)-1:0].
  - Aligned means off is a multiple of 2^in_size.
- Accept condition: in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- IDLE, on accept:
  - Register all request fields.
  - Go to REQ; req=1 from the next cycle.
  - No combinational path from in_* to req/addr.
- REQ:
  - req, addr, wr, size, wstrb, wdata held stable until addr_ok.
  - addr_ok=1 → WAIT; req drops the same clock edge.
- WAIT:
  - On data_ok, load the result register and go to IDLE; out_valid=1 next cycle.
  - Load: out_data = rdata >> (8*off), truncated to 2^size bytes, then sign- or zero-extended to DATA_W.
  - Store: out_data = 0.
  - data_ok is ignored in IDLE and REQ.
- Store lanes:
  - wstrb = ((1<<2^size)-1) << off.
  - wdata = in_wdata low 2^size bytes replicated across DATA_W.
  - For loads, wstrb = 0.
- Result register:
  - out_valid holds until out_ready; out_* stay stable while held.
  - Back-to-back: accept is allowed in the same cycle that out_valid&out_ready.
- Flush:
  - In REQ with !addr_ok: drop req next cycle, return to IDLE, no result.
  - In REQ with addr_ok in the same cycle: go to WAIT with cancel=1.
  - In WAIT: set cancel=1; the matching data_ok is consumed without producing out_valid; then IDLE, cancel=0.
  - flush clears out_valid.
- Reset mid-operation: immediate return to IDLE; any later data_ok is ignored.
- Latency: accept T, req T+1; out_valid one cycle after data_ok. Minimum 3 cycles with addr_ok at T+1 and data_ok at T+2.

Optional Feature:
- Macro EXE_MEM_ALE_EN.
- Defined:
  - A misaligned op is accepted but issues no req.
  - FSM goes IDLE→IDLE and out_valid rises next cycle with exc_ale=1, bad_addr=in_addr, out_data=0.
- Undefined:
  - No alignment check; off bits below the size alignment are forced to 0 in addr, wstrb and data shifting.
  - exc_ale and bad_addr are tied to 0.

Test Plan:
- DATA_W=32 byte store, addr 0x1003, wdata 0x000000A5: req T+1, wstrb 4'b1000, wdata 0xA5A5A5A5; addr_ok T+1, data_ok T+2 → out_valid T+3, out_data 0.
- Half load, sign, addr 0x2002, rdata 0x8001_1234: out_data 0xFFFF8001. Same case unsigned: 0x00008001.
- DATA_W=64 dword store, addr 0x10: wstrb 8'hFF. Word load at off 4, rdata hi word 0x7FFF_FFFF: out_data 0x000000007FFFFFFF.
- addr_ok held low 5 cycles: req and addr stable throughout. flush in WAIT, then data_ok: no out_valid, next accept proceeds normally.
- out_ready low 3 cycles after a result: out_data held, in_ready=0; same-cycle out_ready plus new in_valid accepts.
- With EXE_MEM_ALE_EN, word load at 0x1002: no req, exc_ale=1, bad_addr 0x1002 next cycle. Without the macro: req addr 0x1000.
